// File: rtl/input_buffer_reader.sv
// input_buffer_reader: sweeps buffer addresses per neuron fold, one read in flight, forwards words on a valid/ready stream
module input_buffer_reader #(
    parameter int ADDRESS_WIDTH       = 12,
    parameter int SYNOPSE_FOLD        = 18,
    parameter int SIMD_WIDTH          = 32,
    parameter int BINARY_INPUT_LEVELS = 2,
    parameter int NEURON_FOLD         = 4,
    parameter int TIMEOUT             = 15
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      err,
    output logic                                      buf_enable,
    output logic                                      buf_rwEn,
    output logic [ADDRESS_WIDTH-1:0]                  buf_address,
    input  logic [SIMD_WIDTH*BINARY_INPUT_LEVELS-1:0] buf_data,
    input  logic                                      buf_ready,
    output logic [SIMD_WIDTH*BINARY_INPUT_LEVELS-1:0] out_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic                                      out_last,
    output logic                                      out_pass_last
);
    localparam int W  = SIMD_WIDTH * BINARY_INPUT_LEVELS;
    localparam int PW = $clog2(NEURON_FOLD) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_LAST = ADDRESS_WIDTH'(SYNOPSE_FOLD - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = ADDRESS_WIDTH'(1);
    localparam logic [PW-1:0]            PASS_LAST = PW'(NEURON_FOLD - 1);
    localparam logic [PW-1:0]            PASS_ONE  = PW'(1);
    localparam logic [TW-1:0]            WAIT_END  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]            WAIT_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0]            WAIT_ONE  = TW'(1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_OUT, S_DONE, S_ERR} state_t;

    state_t                   state_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [PW-1:0]            pass_q;
    logic [TW-1:0]            wait_q;
    logic                     busy_q, done_q, err_q, buf_en_q, out_valid_q, out_last_q, out_pass_last_q;
    logic [ADDRESS_WIDTH-1:0] buf_addr_q;
    logic [W-1:0]             out_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            pass_q          <= '0;
            wait_q          <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            buf_en_q        <= 1'b0;
            buf_addr_q      <= '0;
            out_data_q      <= '0;
            out_valid_q     <= 1'b0;
            out_last_q      <= 1'b0;
            out_pass_last_q <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            buf_en_q <= 1'b0;
            case (state_q)
                S_IDLE, S_ERR: if (start) begin
                    state_q    <= S_REQ;
                    addr_q     <= '0;
                    pass_q     <= '0;
                    wait_q     <= '0;
                    err_q      <= 1'b0;
                    busy_q     <= 1'b1;
                    buf_en_q   <= 1'b1;
                    buf_addr_q <= '0;
                end
                S_REQ: state_q <= S_WAIT;
                S_WAIT: if (buf_ready) begin
                    out_data_q      <= buf_data;
                    out_last_q      <= addr_q == ADDR_LAST;
                    out_pass_last_q <= pass_q == PASS_LAST;
                    out_valid_q     <= 1'b1;
                    state_q         <= S_OUT;
                end else if (wait_q == WAIT_END) begin
                    wait_q  <= WAIT_MAX;
                    err_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_ERR;
                end else begin
                    wait_q <= wait_q + WAIT_ONE;
                end
                S_OUT: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    wait_q      <= '0;
                    if (addr_q != ADDR_LAST) begin
                        addr_q     <= addr_q + ADDR_ONE;
                        buf_addr_q <= addr_q + ADDR_ONE;
                        buf_en_q   <= 1'b1;
                        state_q    <= S_REQ;
                    end else if (pass_q != PASS_LAST) begin
                        addr_q     <= '0;
                        pass_q     <= pass_q + PASS_ONE;
                        buf_addr_q <= '0;
                        buf_en_q   <= 1'b1;
                        state_q    <= S_REQ;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign buf_enable    = buf_en_q;
    assign buf_rwEn      = buf_en_q;
    assign buf_address   = buf_addr_q;
    assign out_data      = out_data_q;
    assign out_valid     = out_valid_q;
    assign out_last      = out_last_q;
    assign out_pass_last = out_pass_last_q;
endmodule

// File: tb/tb_input_buffer_reader.sv
// tb_input_buffer_reader: directed bench for input_buffer_reader with a 1-cycle buffer model
module tb_input_buffer_reader;
    localparam int AW = 12, SF = 4, SW = 32, BL = 2, NF = 2, TO = 15, W = SW * BL;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1, respond = 1'b1;
    logic          busy, done, err, buf_enable, buf_rwEn, out_valid, out_last, out_pass_last;
    logic [AW-1:0] buf_address;
    logic [W-1:0]  buf_data = '0, out_data;
    logic          buf_ready = 1'b0;
    int            vectors = 0, miscompares = 0, done_cnt = 0;
    logic [W-1:0]  q_data[$];
    logic          q_last[$], q_pl[$];

    always #5 clk = ~clk;

    input_buffer_reader #(
        .ADDRESS_WIDTH(AW), .SYNOPSE_FOLD(SF), .SIMD_WIDTH(SW),
        .BINARY_INPUT_LEVELS(BL), .NEURON_FOLD(NF), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .buf_enable(buf_enable), .buf_rwEn(buf_rwEn), .buf_address(buf_address),
        .buf_data(buf_data), .buf_ready(buf_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .out_pass_last(out_pass_last)
    );

    // Buffer answers one cycle after the request; junk data otherwise exposes early capture.
    always @(posedge clk) begin
        buf_ready <= buf_enable && respond;
        buf_data  <= (buf_enable && respond) ? 64'(buf_address) * 64'h01010101 : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_last.push_back(out_last);
            q_pl.push_back(out_pass_last);
        end
        if (!rst && done) done_cnt++;
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done(int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick;
            n++;
        end
        chk("done_reached", done, 1);
    endtask

    task automatic wait_valid(int budget);
        int n = 0;
        while (out_valid !== 1'b1 && n < budget) begin
            tick;
            n++;
        end
        chk("valid_reached", out_valid, 1);
    endtask

    task automatic check_run(string tag, int base, int dbase);
        chk({tag, "_words"}, 64'(q_data.size() - base), 64'(SF * NF));
        chk({tag, "_dones"}, 64'(done_cnt - dbase), 1);
        for (int i = 0; i < SF * NF; i++)
            if (base + i < q_data.size()) begin
                chk($sformatf("%s_data%0d", tag, i), q_data[base+i], 64'(i % SF) * 64'h01010101);
                chk($sformatf("%s_last%0d", tag, i), q_last[base+i], (i % SF) == SF - 1);
                chk($sformatf("%s_plast%0d", tag, i), q_pl[base+i], i >= SF * (NF - 1));
            end
    endtask

    initial begin
        int b, d0, n;
        tick;
        tick;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_en", buf_enable, 0);
        chk("rst_rw", buf_rwEn, 0);
        chk("rst_addr", buf_address, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", {out_last, out_pass_last}, 0);
        rst = 1'b0;
        tick;

        b = q_data.size(); d0 = done_cnt;
        pulse_start;
        chk("req_busy", busy, 1);
        chk("req_en", buf_enable, 1);
        chk("req_rw", buf_rwEn, 1);
        chk("req_addr", buf_address, 0);
        chk("req_valid", out_valid, 0);
        tick;
        chk("wait_en", buf_enable, 0);
        chk("wait_rw", buf_rwEn, 0);
        chk("wait_valid", out_valid, 0);
        tick;
        chk("first_valid", out_valid, 1);
        chk("first_data", out_data, 0);
        wait_done(100);
        chk("done_busy", busy, 0);
        chk("done_valid", out_valid, 0);
        tick;
        chk("done_pulse", done, 0);
        check_run("basic", b, d0);

        b = q_data.size(); d0 = done_cnt;
        start = 1'b1;
        tick;
        wait_done(100);
        tick;
        start = 1'b0;
        chk("ign_busy", busy, 0);
        tick;
        chk("ign_busy2", busy, 0);
        chk("ign_en", buf_enable, 0);
        check_run("ignore", b, d0);

        b = q_data.size(); d0 = done_cnt;
        out_ready = 1'b0;
        pulse_start;
        wait_valid(20);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        wait_valid(20);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 64'h01010101);
            chk("bp_en", buf_enable, 0);
        end
        out_ready = 1'b1;
        wait_done(100);
        tick;
        check_run("bp", b, d0);

        respond = 1'b0;
        pulse_start;
        n = 0;
        while (err !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        chk("to_cycles", 64'(n), 16);
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);
        chk("to_valid", out_valid, 0);
        tick;
        tick;
        chk("to_sticky", err, 1);
        respond = 1'b1;
        b = q_data.size(); d0 = done_cnt;
        pulse_start;
        chk("to_clear", err, 0);
        chk("to_rebusy", busy, 1);
        wait_done(100);
        tick;
        check_run("retry", b, d0);

        b = q_data.size(); d0 = done_cnt;
        pulse_start;
        n = 0;
        while (!(out_valid === 1'b1 && q_data.size() - b == 2) && n < 100) begin
            tick;
            n++;
        end
        chk("mid_reached", out_valid, 1);
        rst = 1'b1;
        tick;
        chk("mid_busy", busy, 0);
        chk("mid_valid", out_valid, 0);
        chk("mid_data", out_data, 0);
        chk("mid_en", {buf_enable, buf_rwEn}, 0);
        chk("mid_addr", buf_address, 0);
        chk("mid_flags", {done, err, out_last, out_pass_last}, 0);
        rst = 1'b0;
        repeat (3) tick;
        chk("mid_idle", {busy, out_valid, buf_enable}, 0);
        chk("mid_nodone", 64'(done_cnt - d0), 0);
        chk("mid_words", 64'(q_data.size() - b), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
